// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: a - b - c processed DIGIT bits per cycle,
// LSB digit first, with the borrow rippling through a register between cycles.
module serial_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o,
   output logic             zero_o
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             brw_q, brw_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             zero_q, zero_d;

   logic [DIGIT-1:0] a_dig, b_dig;
   logic [DIGIT:0]   sub;
   int               base;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      brw_d   = brw_q;
      res_d   = res_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      zero_d  = zero_q;

      base  = int'(cnt_q) * DIGIT;
      a_dig = a_q[base +: DIGIT];
      b_dig = b_q[base +: DIGIT];
      // One extra bit catches the borrow: a negative digit result sets the MSB.
      sub   = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, brw_q};

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               brw_d   = c_i;
               cnt_d   = '0;
               res_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            res_d[base +: DIGIT] = sub[DIGIT-1:0];
            brw_d                = sub[DIGIT];
            cnt_d                = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(N - 1)) begin
               // Outputs only change here, so they never expose partial digits.
               diff_d  = res_d;
               bout_d  = sub[DIGIT];
               zero_d  = (res_d == '0);
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         brw_q   <= 1'b0;
         res_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         brw_q   <= brw_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
      end
   end

   assign busy_o   = (state_q == S_RUN);
   assign done_o   = (state_q == S_DONE);
   assign diff_o   = diff_q;
   assign borrow_o = bout_q;
   assign zero_o   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: three instances (DIGIT = 1, 4, 16) checked
// against an arithmetic reference of a - b - c.
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start [3];
   logic [15:0] a     [3];
   logic [15:0] b     [3];
   logic        c     [3];
   logic        busy  [3];
   logic        done  [3];
   logic [15:0] diff  [3];
   logic        borrow[3];
   logic        zero  [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_d1 (
      .clk_i(clk), .rst_i(rst), .start_i(start[0]), .a_i(a[0]), .b_i(b[0]), .c_i(c[0]),
      .busy_o(busy[0]), .done_o(done[0]), .diff_o(diff[0]), .borrow_o(borrow[0]), .zero_o(zero[0]));

   serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_d4 (
      .clk_i(clk), .rst_i(rst), .start_i(start[1]), .a_i(a[1]), .b_i(b[1]), .c_i(c[1]),
      .busy_o(busy[1]), .done_o(done[1]), .diff_o(diff[1]), .borrow_o(borrow[1]), .zero_o(zero[1]));

   serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_d16 (
      .clk_i(clk), .rst_i(rst), .start_i(start[2]), .a_i(a[2]), .b_i(b[2]), .c_i(c[2]),
      .busy_o(busy[2]), .done_o(done[2]), .diff_o(diff[2]), .borrow_o(borrow[2]), .zero_o(zero[2]));

   function automatic int n_of(input int idx);
      case (idx)
         0:       return 16;
         1:       return 4;
         default: return 1;
      endcase
   endfunction

   // Full subtraction and borrow computed directly on the unsigned integer values.
   function automatic logic [15:0] ref_diff(input logic [15:0] av, bv, input logic cv);
      int t;
      t = int'(av) - int'(bv) - int'(cv);
      return 16'(t + 65536);
   endfunction

   function automatic logic ref_borrow(input logic [15:0] av, bv, input logic cv);
      return int'(av) < (int'(bv) + int'(cv));
   endfunction

   // Issue one operation on instance idx, check latency, result and the done pulse.
   task automatic run_op(input int idx, input logic [15:0] av, bv, input logic cv);
      int          edges;
      logic [15:0] ed;
      logic        eb;
      ed = ref_diff(av, bv, cv);
      eb = ref_borrow(av, bv, cv);
      @(negedge clk);
      start[idx] = 1'b1; a[idx] = av; b[idx] = bv; c[idx] = cv;
      @(posedge clk); #1;
      start[idx] = 1'b0;
      a[idx] = 16'($urandom); b[idx] = 16'($urandom); c[idx] = 1'($urandom);
      n_cmp++;
      if (busy[idx] !== 1'b1) begin
         n_bad++; $display("FAIL busy_after_accept[%0d]: got %b want 1", idx, busy[idx]);
      end
      edges = 0;
      while (done[idx] !== 1'b1 && edges < 64) begin
         @(posedge clk); #1;
         edges++;
      end
      n_cmp++;
      if (edges !== n_of(idx)) begin
         n_bad++; $display("FAIL latency[%0d]: got %0d edges want %0d", idx, edges, n_of(idx));
      end
      n_cmp++;
      if (diff[idx] !== ed || borrow[idx] !== eb || zero[idx] !== (ed == 16'h0) || busy[idx] !== 1'b0) begin
         n_bad++;
         $display("FAIL result[%0d] %h-%h-%b: got diff=%h brw=%b zero=%b busy=%b want diff=%h brw=%b zero=%b busy=0",
                  idx, av, bv, cv, diff[idx], borrow[idx], zero[idx], busy[idx], ed, eb, ed == 16'h0);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done[idx] !== 1'b0 || diff[idx] !== ed) begin
         n_bad++; $display("FAIL done_pulse[%0d]: got done=%b diff=%h want done=0 diff=%h", idx, done[idx], diff[idx], ed);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({busy[i], done[i], diff[i], borrow[i], zero[i]} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_outputs[%0d]: got busy=%b done=%b diff=%h brw=%b zero=%b want all 0",
                     i, busy[i], done[i], diff[i], borrow[i], zero[i]);
         end
      end
      // Start held during reset must only take effect on the first edge after release.
      @(negedge clk);
      start[1] = 1'b1; a[1] = 16'h0010; b[1] = 16'h0003; c[1] = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (busy[1] !== 1'b0) begin
         n_bad++; $display("FAIL start_during_reset: got busy=%b want 0", busy[1]);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      start[1] = 1'b0;
      n_cmp++;
      if (busy[1] !== 1'b1) begin
         n_bad++; $display("FAIL start_after_release: got busy=%b want 1", busy[1]);
      end
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (done[1] !== 1'b1 || diff[1] !== 16'h000C || borrow[1] !== 1'b0) begin
         n_bad++; $display("FAIL release_result: got done=%b diff=%h brw=%b want done=1 diff=000c brw=0",
                           done[1], diff[1], borrow[1]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_op(1, 16'h1234, 16'h0234, 1'b0);
      run_op(1, 16'h0000, 16'h0001, 1'b0);
      run_op(1, 16'h0005, 16'h0005, 1'b1);
      run_op(1, 16'h8000, 16'h8000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         run_op(i, 16'hFFFF, 16'h0000, 1'b0);
         run_op(i, 16'h0000, 16'hFFFF, 1'b1);
      end
   endtask

   task automatic test_ignore_start();
      run_op(1, 16'h1234, 16'h0234, 1'b0);
      @(negedge clk);
      start[1] = 1'b1; a[1] = 16'h0000; b[1] = 16'h0001; c[1] = 1'b0;
      @(posedge clk); #1;                       // edge k
      start[1] = 1'b0;
      @(posedge clk); #1;                       // edge k+1
      @(negedge clk);
      start[1] = 1'b1; a[1] = 16'h7777; b[1] = 16'h1111;
      @(posedge clk); #1;                       // edge k+2
      start[1] = 1'b0;
      n_cmp++;
      if (diff[1] !== 16'h1000 || done[1] !== 1'b0 || busy[1] !== 1'b1) begin
         n_bad++; $display("FAIL hold_k2: got diff=%h done=%b busy=%b want diff=1000 done=0 busy=1",
                           diff[1], done[1], busy[1]);
      end
      @(posedge clk); #1;                       // edge k+3
      n_cmp++;
      if (diff[1] !== 16'h1000 || busy[1] !== 1'b1) begin
         n_bad++; $display("FAIL hold_k3: got diff=%h busy=%b want diff=1000 busy=1", diff[1], busy[1]);
      end
      @(posedge clk); #1;                       // edge k+4
      n_cmp++;
      if (done[1] !== 1'b1 || diff[1] !== 16'hFFFF || borrow[1] !== 1'b1) begin
         n_bad++; $display("FAIL ignore_result: got done=%b diff=%h brw=%b want done=1 diff=ffff brw=1",
                           done[1], diff[1], borrow[1]);
      end
      @(negedge clk);
      start[1] = 1'b1;
      @(posedge clk); #1;                       // edge k+5
      start[1] = 1'b0;
      @(posedge clk); #1;                       // edge k+6
      n_cmp++;
      if (done[1] !== 1'b0 || busy[1] !== 1'b0 || diff[1] !== 16'hFFFF) begin
         n_bad++; $display("FAIL start_in_done: got done=%b busy=%b diff=%h want done=0 busy=0 diff=ffff",
                           done[1], busy[1], diff[1]);
      end
   endtask

   task automatic test_reset_mid_run();
      int pulses;
      @(negedge clk);
      start[1] = 1'b1; a[1] = 16'h00FF; b[1] = 16'h0001; c[1] = 1'b0;
      @(posedge clk); #1;                       // edge k
      start[1] = 1'b0;
      @(posedge clk);                           // edge k+1
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;                       // edge k+2
      n_cmp++;
      if ({busy[1], done[1], diff[1], borrow[1], zero[1]} !== 20'h0) begin
         n_bad++; $display("FAIL mid_reset: got busy=%b done=%b diff=%h brw=%b zero=%b want all 0",
                           busy[1], done[1], diff[1], borrow[1], zero[1]);
      end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done[1] === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin
         n_bad++; $display("FAIL aborted_done: got %0d done pulses want 0", pulses);
      end
      run_op(1, 16'hABCD, 16'h1234, 1'b1);
   endtask

   task automatic test_random_sweep();
      for (int i = 0; i < 3; i++) begin
         for (int t = 0; t < 1000; t++) begin
            run_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0; a[i] = '0; b[i] = '0; c[i] = 1'b0;
      end
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_mid_run();
      test_random_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
